bamse_irq_ctrl: RTL and testbench

//  Interrupt controller that shares the single PacoBlaze3 interrupt input among N_SRC peripheral sources.
//  Per-source edge detect, pending latch, mask, fixed-priority vector and ack/EOI sequencing.

---
 rtl/bamse_irq_ctrl_pkg.sv | 33 +++
 rtl/bamse_irq_ctrl_if.sv | 22 ++
 rtl/irq_edge_sync.sv | 38 +++
 rtl/bamse_irq_ctrl.sv | 113 +++++++++++
 tb/tb_bamse_irq_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bamse_irq_ctrl_pkg.sv
// Shared constants and types for the PacoBlaze interrupt controller:
// register offsets, FSM encodings, vector payload and priority helper.
package bamse_irq_ctrl_pkg;

    localparam int unsigned REG_W = 8;
    localparam int unsigned IDX_W = 3;

    localparam logic [1:0] IRQC_PEND = 2'd0;
    localparam logic [1:0] IRQC_MASK = 2'd1;
    localparam logic [1:0] IRQC_VEC  = 2'd2;
    localparam logic [1:0] IRQC_EOI  = 2'd3;

    typedef enum logic [1:0] {
        IRQC_IDLE    = 2'd0,
        IRQC_ASSERT  = 2'd1,
        IRQC_SERVICE = 2'd2
    } irqc_state_e;

    typedef struct packed {
        logic             valid;
        logic [3:0]       rsvd;
        logic [IDX_W-1:0] idx;
    } irqc_vec_t;

    // Lowest set index wins; returns 0 when nothing is set.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [REG_W-1:0] v);
        lowest_idx = '0;
        for (int i = REG_W - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/bamse_irq_ctrl_if.sv
// PacoBlaze I/O bus and interrupt handshake as seen by the interrupt controller.
interface bamse_irq_ctrl_if;

    logic [7:0] port_id;
    logic [7:0] port_in;
    logic [7:0] port_out;
    logic       wen;
    logic       ren;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id, port_in, wen, ren, interrupt_ack,
        input  port_out, interrupt
    );

    modport slave (
        input  port_id, port_in, wen, ren, interrupt_ack,
        output port_out, interrupt
    );

endinterface

// File: rtl/irq_edge_sync.sv
// Two-flop synchroniser plus rising-edge detect for one interrupt source.
// Edges are suppressed until the history flop holds a real sample after reset.
module irq_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic rise_pulse
);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       prev_q, prev_d;
    logic [2:0] vld_q, vld_d;

    always_comb begin
        s1_d   = src;
        s2_d   = s1_q;
        prev_d = s2_q;
        vld_d  = {vld_q[1:0], 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            vld_q  <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
            vld_q  <= vld_d;
        end
    end

    assign rise_pulse = s2_q & ~prev_q & vld_q[2];

endmodule

// File: rtl/bamse_irq_ctrl.sv
// Interrupt controller sharing the single PacoBlaze interrupt among N_SRC sources:
// pending/mask registers, fixed-priority vector, ack/EOI sequencing.
module bamse_irq_ctrl
    import bamse_irq_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC     = 8,
    parameter logic [7:0]  BASE_ADDR = 8'hF0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    bamse_irq_ctrl_if.slave  bus
);

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] enabled, wdata, clr;
    irqc_vec_t        vec_q, vec_d;
    irqc_state_e      state_q, state_d;
    logic             irq_q, irq_d;
    logic [7:0]       off;
    logic             hit, wr_pend, wr_mask, wr_eoi, ack_take, any_en;
    logic [IDX_W-1:0] idx;
    logic             unused_ren;

    assign unused_ren = bus.ren;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        irq_edge_sync u_sync (
            .clk        (clk),
            .rst        (rst),
            .src        (irq_src[g]),
            .rise_pulse (rise[g])
        );
    end

    always_comb begin : decode
        off      = bus.port_id - BASE_ADDR;
        hit      = (off < 8'd4);
        wdata    = bus.port_in[N_SRC-1:0];
        wr_pend  = bus.wen && hit && (off[1:0] == IRQC_PEND);
        wr_mask  = bus.wen && hit && (off[1:0] == IRQC_MASK);
        wr_eoi   = bus.wen && hit && (off[1:0] == IRQC_EOI);
        enabled  = pend_q & mask_q;
        any_en   = |enabled;
        idx      = lowest_idx(REG_W'(enabled));
        ack_take = (state_q == IRQC_ASSERT) && bus.interrupt_ack;
    end

    // A new edge on a bit overrides both W1C and the ack clear in the same cycle.
    always_comb begin : regs
        clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr[i] = ack_take && any_en && (idx == IDX_W'(i));
        end
        pend_d = (pend_q & ~(wr_pend ? wdata : '0) & ~clr) | rise;
        mask_d = wr_mask ? wdata : mask_q;
        vec_d  = vec_q;
        if (ack_take) begin
            vec_d = '0;
            if (any_en) begin
                vec_d.valid = 1'b1;
                vec_d.idx   = idx;
            end
        end
    end

    always_comb begin : fsm
        state_d = state_q;
        case (state_q)
            IRQC_IDLE:    if (any_en) state_d = IRQC_ASSERT;
            IRQC_ASSERT: begin
                if (bus.interrupt_ack) state_d = IRQC_SERVICE;
                else if (!any_en)      state_d = IRQC_IDLE;
            end
            IRQC_SERVICE: if (wr_eoi) state_d = IRQC_IDLE;
            default:      state_d = IRQC_IDLE;
        endcase
        irq_d = (state_d == IRQC_ASSERT);
    end

    always_comb begin : rd_mux
        bus.port_out = 8'h00;
        if (hit) begin
            case (off[1:0])
                IRQC_PEND: bus.port_out = 8'(pend_q);
                IRQC_MASK: bus.port_out = 8'(mask_q);
                IRQC_VEC:  bus.port_out = 8'(vec_q);
                default:   bus.port_out = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IRQC_IDLE;
            irq_q   <= 1'b0;
            pend_q  <= '0;
            mask_q  <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            vec_q   <= vec_d;
        end
    end

    assign bus.interrupt = irq_q;

endmodule

// File: tb/tb_bamse_irq_ctrl.sv
// Directed bench for bamse_irq_ctrl: stimulus pushes expected reads/interrupt
// levels into a scoreboard queue, a negedge monitor pops and compares.
module tb_bamse_irq_ctrl;

    localparam logic [7:0] A_PEND = 8'hF0;
    localparam logic [7:0] A_MASK = 8'hF1;
    localparam logic [7:0] A_VEC  = 8'hF2;
    localparam logic [7:0] A_EOI  = 8'hF3;

    typedef struct {
        bit         is_irq;
        logic [7:0] exp;
        string      name;
    } sb_t;

    logic       clk;
    logic       rst;
    logic [7:0] irq_src;
    logic       irq_chk;
    int         checks;
    int         errors;
    sb_t        sb[$];

    bamse_irq_ctrl_if bus();

    bamse_irq_ctrl #(.N_SRC(8), .BASE_ADDR(8'hF0)) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input bit is_irq, input logic [7:0] got);
        sb_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %02h with nothing expected", got);
            return;
        end
        e = sb.pop_front();
        if (e.is_irq != is_irq || got !== e.exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", e.name, got, e.exp);
        end
    endtask

    // Monitor: a read strobe presents port_out, irq_chk presents the interrupt line.
    always @(negedge clk) begin
        if (bus.ren) check(1'b0, bus.port_out);
        if (irq_chk) check(1'b1, {7'b0, bus.interrupt});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input bit do_rd, input logic [7:0] pid, input logic [7:0] ed,
                         input bit do_irq, input bit ei, input string nm);
        if (do_rd) begin
            sb.push_back('{1'b0, ed, {nm, "/rd"}});
            bus.port_id = pid;
            bus.ren     = 1'b1;
        end
        if (do_irq) begin
            sb.push_back('{1'b1, {7'b0, ei}, {nm, "/irq"}});
            irq_chk = 1'b1;
        end
        @(negedge clk);
        #1;
        bus.ren     = 1'b0;
        irq_chk     = 1'b0;
        bus.port_id = 8'h00;
    endtask

    task automatic rd(input logic [7:0] pid, input logic [7:0] ed, input string nm);
        probe(1'b1, pid, ed, 1'b0, 1'b0, nm);
    endtask

    task automatic ir(input bit ei, input string nm);
        probe(1'b0, 8'h00, 8'h00, 1'b1, ei, nm);
    endtask

    task automatic rdir(input logic [7:0] pid, input logic [7:0] ed, input bit ei, input string nm);
        probe(1'b1, pid, ed, 1'b1, ei, nm);
    endtask

    task automatic wr(input logic [7:0] pid, input logic [7:0] d);
        bus.port_id = pid;
        bus.port_in = d;
        bus.wen     = 1'b1;
        tick();
        bus.wen     = 1'b0;
        bus.port_id = 8'h00;
    endtask

    task automatic ack();
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
    endtask

    // Leaves the source high across two edges; the edge is flagged after the second.
    task automatic pulse(input logic [7:0] m);
        irq_src = irq_src | m;
        tick();
        tick();
        irq_src = irq_src & ~m;
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        irq_chk           = 1'b0;
        rst               = 1'b1;
        irq_src           = 8'h00;
        bus.port_id       = 8'h00;
        bus.port_in       = 8'h00;
        bus.wen           = 1'b0;
        bus.ren           = 1'b0;
        bus.interrupt_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // reset state and decode
        rdir(A_PEND, 8'h00, 1'b0, "rst_pend"); tick();
        rd(A_MASK, 8'h00, "rst_mask");         tick();
        rd(A_VEC,  8'h00, "rst_vec");          tick();

        // 1: single source, full ack/EOI cycle
        wr(A_MASK, 8'h05);
        rd(A_MASK, 8'h05, "t1_mask");          tick();
        rd(8'hF4,  8'h00, "t1_above_range");   tick();
        rd(8'hEF,  8'h00, "t1_below_range");   tick();
        rd(A_EOI,  8'h00, "t1_eoi_reads0");
        pulse(8'h04);
        rd(A_PEND, 8'h00, "t1_pend_not_yet");  tick();
        rdir(A_PEND, 8'h04, 1'b0, "t1_pend_set"); tick();
        ir(1'b1, "t1_irq_up");
        ack();
        rdir(A_VEC, 8'h82, 1'b0, "t1_vec");    tick();
        rd(A_PEND, 8'h00, "t1_pend_cleared");
        wr(A_EOI, 8'h00);
        ir(1'b0, "t1_after_eoi");              tick();
        ir(1'b0, "t1_stays_idle");

        // 2: two sources, priority then back-to-back
        wr(A_MASK, 8'hFF);
        pulse(8'h22);                          tick();
        rdir(A_PEND, 8'h22, 1'b0, "t2_pend");  tick();
        ir(1'b1, "t2_irq_up");
        ack();
        rdir(A_VEC, 8'h81, 1'b0, "t2_vec_first"); tick();
        rd(A_PEND, 8'h20, "t2_pend_left");
        wr(A_EOI, 8'h00);
        ir(1'b0, "t2_idle_gap");               tick();
        ir(1'b1, "t2_reassert");
        ack();
        rd(A_VEC, 8'h85, "t2_vec_second");     tick();
        rdir(A_PEND, 8'h00, 1'b0, "t2_pend_empty");
        wr(A_EOI, 8'h00);

        // 3: pending while masked, then unmask
        wr(A_MASK, 8'h00);
        pulse(8'h08);                          tick();
        rdir(A_PEND, 8'h08, 1'b0, "t3_pend_masked"); tick();
        ir(1'b0, "t3_masked_quiet");
        wr(A_MASK, 8'h08);
        ir(1'b0, "t3_unmask_gap");             tick();
        ir(1'b1, "t3_unmask_irq");
        ack();
        rd(A_VEC, 8'h83, "t3_vec");            tick();
        wr(A_EOI, 8'h00);

        // 4: W1C while asserting, stray ack, spurious ack
        wr(A_MASK, 8'h01);
        pulse(8'h01);                          tick(); tick();
        ir(1'b1, "t4_irq_up");
        wr(A_PEND, 8'h01);                     tick();
        rdir(A_PEND, 8'h00, 1'b0, "t4_w1c_drop"); tick();
        ack();
        rdir(A_VEC, 8'h83, 1'b0, "t4_ack_idle_ignored"); tick();
        pulse(8'h01);                          tick(); tick();
        wr(A_PEND, 8'h01);
        ack();
        rdir(A_VEC, 8'h00, 1'b0, "t4_spurious_vec"); tick();
        wr(A_EOI, 8'h00);                      tick();
        ir(1'b0, "t4_after_spurious");

        // 5: edge vs W1C on the same bit, edges during service
        wr(A_MASK, 8'h00);
        pulse(8'h10);                          tick();
        rd(A_PEND, 8'h10, "t5_pend_first");
        pulse(8'h10);
        wr(A_PEND, 8'h10);
        rd(A_PEND, 8'h10, "t5_set_wins");      tick();
        wr(A_PEND, 8'h10);
        rd(A_PEND, 8'h00, "t5_plain_w1c");     tick();
        wr(A_MASK, 8'hFF);
        pulse(8'h10);                          tick(); tick();
        ir(1'b1, "t5_irq_up");
        ack();
        pulse(8'h41);                          tick();
        rdir(A_PEND, 8'h41, 1'b0, "t5_pend_in_service"); tick();
        ir(1'b0, "t5_service_quiet");
        ack();
        rdir(A_VEC, 8'h84, 1'b0, "t5_ack_service_ignored"); tick();
        wr(A_EOI, 8'h00);                      tick();
        ir(1'b1, "t5_reassert");
        ack();
        rdir(A_VEC, 8'h80, 1'b0, "t5_vec_src0"); tick();
        rd(A_PEND, 8'h40, "t5_pend_src6");
        wr(A_EOI, 8'h00);                      tick();
        ir(1'b1, "t5_reassert2");
        ack();
        rd(A_VEC, 8'h86, "t5_vec_src6");       tick();
        wr(A_EOI, 8'h00);

        // 6: reset mid-service, level-high source produces no edge afterwards
        pulse(8'h30);                          tick(); tick();
        ack();
        pulse(8'h10);                          tick();
        rdir(A_PEND, 8'h30, 1'b0, "t6_pend_before_rst");
        irq_src[7] = 1'b1;
        tick();
        rst = 1'b1;
        rdir(A_PEND, 8'h00, 1'b0, "t6_rst_pend"); tick();
        rd(A_MASK, 8'h00, "t6_rst_mask");      tick();
        rd(A_VEC,  8'h00, "t6_rst_vec");       tick();
        rst = 1'b0;
        repeat (6) tick();
        rdir(A_PEND, 8'h00, 1'b0, "t6_no_edge_high_src");
        wr(A_MASK, 8'hFF);
        repeat (3) tick();
        rdir(A_PEND, 8'h00, 1'b0, "t6_still_quiet"); tick();
        irq_src[7] = 1'b0;
        repeat (3) tick();
        pulse(8'h80);                          tick();
        rd(A_PEND, 8'h80, "t6_new_edge");      tick();
        ir(1'b1, "t6_new_irq");

        repeat (2) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected entries never checked, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
